// File: rtl/fb_pkg.sv
// Shared frame-buffer constants: geometry, requester indices and swap FSM states.
// Used by frame_buffer, the drawers, graphics_fsm and the write arbiter.
package fb_pkg;

    localparam int FB_HOR_ACTIVE = 640;
    localparam int FB_VER_ACTIVE = 480;
    localparam int PIXELS_COUNT  = FB_HOR_ACTIVE * FB_VER_ACTIVE;
    localparam int ADDR_WIDTH    = $clog2(PIXELS_COUNT);

    localparam int FB_N_REQ   = 3;
    localparam int REQ_FILL   = 0;
    localparam int REQ_LINE   = 1;
    localparam int REQ_SYMBOL = 2;

    typedef enum logic [1:0] {
        SWP_IDLE  = 2'd0,
        SWP_DRAIN = 2'd1,
        SWP_SWAP  = 2'd2
    } swap_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating priority encoder: first set request at or after i_start wins.
// A start of zero gives plain lowest-index-first priority.
module rr_priority_encoder
    import fb_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_start,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((32'(i_start) + 32'(k)) % 32'(N));
            if (!w_found && i_req[w_cand]) begin
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_buffer_write_arbiter.sv
// Single write port arbiter for the frame buffer with a registered output stage and swap sequencing.
// Define FB_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module frame_buffer_write_arbiter
    import fb_pkg::*;
#(
    parameter int HOR_ACTIVE_PIXELS = FB_HOR_ACTIVE,
    parameter int VER_ACTIVE_PIXELS = FB_VER_ACTIVE,
    parameter int N_REQ             = FB_N_REQ
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ-1:0]              req_data,
    output logic                          fb_write_enable,
    output logic [ADDR_WIDTH-1:0]         fb_write_addr,
    output logic                          fb_write_data,
    input  logic                          swap_req,
    output logic                          swap,
    output logic                          busy,
    output logic                          oob_error
);

    localparam int IW        = idx_width(N_REQ);
    localparam int PIX_LIMIT = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS;

    swap_state_e           r_state;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_data;
    logic                  r_swap;
    logic                  r_oob;

    logic [N_REQ-1:0]      w_grant;
    logic [IW-1:0]         w_gidx;
    logic [IW-1:0]         w_start;
    logic                  w_idle;
    logic                  w_xfer;
    logic                  w_in_range;
    logic                  w_wr_next;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_sel_data;

    rr_priority_encoder #(
        .N  (N_REQ),
        .IW (IW)
    ) u_enc (
        .i_req   (req_valid),
        .i_start (w_start),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

`ifdef FB_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] r_ptr;

    // Pointer holds the last winner; search begins just after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IW'(N_REQ - 1);
        end else if (w_xfer) begin
            r_ptr <= w_gidx;
        end
    end

    assign w_start = (r_ptr == IW'(N_REQ - 1)) ? '0 : r_ptr + 1'b1;
`else
    assign w_start = '0;
`endif

    assign w_idle     = (r_state == SWP_IDLE);
    assign req_ready  = w_grant & {N_REQ{w_idle}};
    assign w_xfer     = |req_ready;
    assign w_sel_addr = req_addr[int'(w_gidx) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = req_data[w_gidx];
    assign w_in_range = (32'(w_sel_addr) < 32'(PIX_LIMIT));
    assign w_wr_next  = w_xfer & w_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= 1'b0;
            r_oob  <= 1'b0;
        end else begin
            r_we   <= w_wr_next;
            r_addr <= w_wr_next ? w_sel_addr : '0;
            r_data <= w_wr_next ? w_sel_data : 1'b0;
            if (w_xfer && !w_in_range) begin
                r_oob <= 1'b1;
            end
        end
    end

    // DRAIN waits until no write will occupy the output stage on the swap cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SWP_IDLE;
            r_swap  <= 1'b0;
        end else begin
            r_swap <= 1'b0;
            unique case (r_state)
                SWP_IDLE: begin
                    if (swap_req) begin
                        r_state <= SWP_DRAIN;
                    end
                end
                SWP_DRAIN: begin
                    if (!w_wr_next) begin
                        r_state <= SWP_SWAP;
                        r_swap  <= 1'b1;
                    end
                end
                SWP_SWAP: begin
                    r_state <= SWP_IDLE;
                end
                default: begin
                    r_state <= SWP_IDLE;
                end
            endcase
        end
    end

    assign fb_write_enable = r_we;
    assign fb_write_addr   = r_addr;
    assign fb_write_data   = r_data;
    assign swap            = r_swap;
    assign oob_error       = r_oob;
    assign busy            = (r_state != SWP_IDLE) | r_we;

endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// Scoreboard bench for frame_buffer_write_arbiter with a queue-based reference model.
// Honours FB_ARB_ROUND_ROBIN_EN the same way the design does.
module tb_frame_buffer_write_arbiter;
    import fb_pkg::*;

    localparam int N    = 3;
    localparam int AW   = ADDR_WIDTH;
    localparam int PIX  = PIXELS_COUNT;
    localparam int NCYC = 1500;
    localparam int NDRN = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_data;
    logic            fb_write_enable;
    logic [AW-1:0]   fb_write_addr;
    logic            fb_write_data;
    logic            swap_req;
    logic            swap;
    logic            busy;
    logic            oob_error;

    always #5 clk = ~clk;

    frame_buffer_write_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .fb_write_enable (fb_write_enable),
        .fb_write_addr   (fb_write_addr),
        .fb_write_data   (fb_write_data),
        .swap_req        (swap_req),
        .swap            (swap),
        .busy            (busy),
        .oob_error       (oob_error)
    );

    typedef struct {
        int          stamp;
        logic [AW-1:0] addr;
        logic        data;
    } wr_t;

    typedef struct {
        bit          v;
        logic [AW-1:0] a;
        logic        d;
    } pend_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    wr_t  wq[$];
    int   sq[$];
    logic exp_oob  = 1'b0;
    logic exp_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares presented outputs against scoreboard entries.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (fb_write_enable) begin
                    if (wq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = wq.pop_front();
                        chk("write_cycle", cyc, e.stamp);
                        chk("write_addr", 32'(fb_write_addr), 32'(e.addr));
                        chk("write_data", 32'(fb_write_data), 32'(e.data));
                    end
                end else begin
                    chk("idle_bus_zero", {fb_write_addr, fb_write_data}, 0);
                    if (wq.size() > 0 && wq[0].stamp <= cyc) begin
                        chk("missed_write", 0, 1);
                        void'(wq.pop_front());
                    end
                end
                if (swap) begin
                    if (sq.size() == 0) chk("unexpected_swap", 1, 0);
                    else chk("swap_cycle", cyc, sq.pop_front());
                end else if (sq.size() > 0 && sq[0] <= cyc) begin
                    chk("missed_swap", 0, 1);
                    void'(sq.pop_front());
                end
                chk("oob_error", 32'(oob_error), 32'(exp_oob));
                chk("busy", 32'(busy), 32'(exp_busy));
            end
        end
    end

    initial begin
        pend_t        pend[N];
        int           last;
        int           swap_at;
        int           win;
        int           idx;
        int           r;
        bit           oob_next;
        bit           wrote_prev;
        bit           blocked;
        bit           gen;
        logic [N-1:0] exp_ready;

        last       = N - 1;
        swap_at    = -100;
        oob_next   = 1'b0;
        wrote_prev = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = '{v: 1'b0, a: '0, d: 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        swap_req  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(fb_write_enable), 0);
        chk("rst_bus", {fb_write_addr, fb_write_data}, 0);
        chk("rst_swap", 32'(swap), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_oob", 32'(oob_error), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int c = 0; c < NCYC + NDRN; c++) begin
            @(posedge clk);
            cyc      = c;
            mon_en   = 1'b1;
            exp_oob  = oob_next;
            exp_busy = (c >= swap_at - 1 && c <= swap_at) || wrote_prev;
            #1;
            gen = (c < NCYC);
            for (int i = 0; i < N; i++) begin
                if (gen && !pend[i].v &&
                    (c == 0 || $urandom_range(0, 9) < 6)) begin
                    r = int'($urandom_range(0, 19));
                    pend[i].v = 1'b1;
                    pend[i].d = 1'($urandom_range(0, 1));
                    if (r == 0) pend[i].a = AW'(PIX);
                    else if (r == 1) pend[i].a = AW'(PIX + int'($urandom_range(1, 1000)));
                    else if (r == 2) pend[i].a = AW'(PIX - 1);
                    else pend[i].a = AW'($urandom_range(0, PIX - 1));
                end
                req_valid[i]           = pend[i].v;
                req_addr[i*AW +: AW]   = pend[i].a;
                req_data[i]            = pend[i].d;
            end
            swap_req = gen && (c > 0) && ($urandom_range(0, 11) == 0);

            blocked = (c >= swap_at - 1 && c <= swap_at);
            win = -1;
            if (!blocked) begin
`ifdef FB_ARB_ROUND_ROBIN_EN
                for (int k = 1; k <= N; k++) begin
                    idx = (last + k) % N;
                    if (win < 0 && pend[idx].v) win = idx;
                end
`else
                for (int k = 0; k < N; k++) begin
                    if (win < 0 && pend[k].v) win = k;
                end
`endif
            end
            exp_ready = (win >= 0) ? N'(1 << win) : '0;
            #1;
            chk("req_ready", 32'(req_ready), 32'(exp_ready));

            wrote_prev = 1'b0;
            if (win >= 0) begin
                if (int'(pend[win].a) < PIX) begin
                    wq.push_back('{stamp: c + 1, addr: pend[win].a,
                                   data: pend[win].d});
                    wrote_prev = 1'b1;
                end else begin
                    oob_next = 1'b1;
                end
                last = win;
                pend[win].v = 1'b0;
            end
            if (swap_req && c > swap_at) begin
                swap_at = c + 2;
                sq.push_back(c + 2);
            end
        end

        @(posedge clk);
        mon_en = 1'b0;
        #1;
        chk("write_queue_empty", wq.size(), 0);
        chk("swap_queue_empty", sq.size(), 0);
        for (int i = 0; i < N; i++) chk("all_served", 32'(pend[i].v), 0);
        req_valid = '0;
        swap_req  = 1'b1;
        @(posedge clk);
        #1 swap_req = 1'b0;
        #1 chk("drain_busy", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_swap", 32'(swap), 0);
            chk("post_rst_we", 32'(fb_write_enable), 0);
            chk("post_rst_busy", 32'(busy), 0);
            chk("post_rst_oob", 32'(oob_error), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
